// File: rtl/bb_link_scheduler.sv
// bb_link_scheduler
// Shares one UART bus-bridge link between two local requesters.
// A round-robin arbiter picks one requester at a time. Its transaction is
// packed into a single frame {mode, addr, wdata} and handed to the UART TX.
// A read then waits, with a timeout, for the remote read-data byte on UART RX.
//
// Handshake contract:
//   - A requester raises m_req[i] with stable m_mode/m_addr/m_wdata fields.
//   - It keeps them stable until it sees m_grant[i] for one cycle.
//   - Exactly one m_done[i] pulse then follows for that grant, carrying
//     m_rdata and m_err.
//   - A reset that arrives mid-transaction drops it silently.
//   - On the UART side, u_tx_start is a one-cycle launch of u_tx_data.
//     Completion is the rise and then the fall of u_tx_busy.
//   - u_rx_valid is a one-cycle strobe for u_rx_data. It is only heard
//     while a read is waiting.
module bb_link_scheduler #(
  parameter int DATA_WIDTH     = 8,
  parameter int BB_ADDR_WIDTH  = 13,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [1:0]                          m_req,
  input  logic [1:0]                          m_mode,
  input  logic [2*BB_ADDR_WIDTH-1:0]          m_addr,
  input  logic [2*DATA_WIDTH-1:0]             m_wdata,
  output logic [1:0]                          m_grant,
  output logic [1:0]                          m_done,
  output logic [DATA_WIDTH-1:0]               m_rdata,
  output logic                                m_err,
  output logic                                busy,
  output logic [DATA_WIDTH+BB_ADDR_WIDTH:0]   u_tx_data,
  output logic                                u_tx_start,
  input  logic                                u_tx_busy,
  input  logic [DATA_WIDTH-1:0]               u_rx_data,
  input  logic                                u_rx_valid,
  output logic [2:0]                          dbg_state
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_START   = 3'd2,
    S_TX_WAIT = 3'd3,
    S_RD_WAIT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                              r_state;
  state_t                              w_state_nxt;
  logic                                r_win;
  logic                                r_last;
  logic                                r_mode;
  logic [DATA_WIDTH+BB_ADDR_WIDTH:0]   r_tx_data;
  logic                                r_busy_seen;
  logic [CW-1:0]                       r_cnt;
  logic [DATA_WIDTH-1:0]               r_rdata;
  logic                                r_err;

  logic                                w_win;
  logic                                w_sel_mode;
  logic [BB_ADDR_WIDTH-1:0]            w_sel_addr;
  logic [DATA_WIDTH-1:0]               w_sel_wdata;
  logic [DATA_WIDTH-1:0]               w_frame_wdata;
  logic [CW-1:0]                       w_cnt_nxt;
  logic                                w_timeout;
  logic                                w_tx_fall;

  // Arbitration: a lone requester wins; on a tie the one not granted last time wins.
  assign w_win = (m_req == 2'b11) ? ~r_last : m_req[1];

  // Select the winner's request fields; read frames carry zero write data.
  assign w_sel_mode    = w_win ? m_mode[1] : m_mode[0];
  assign w_sel_addr    = w_win ? m_addr[2*BB_ADDR_WIDTH-1:BB_ADDR_WIDTH]
                               : m_addr[BB_ADDR_WIDTH-1:0];
  assign w_sel_wdata   = w_win ? m_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                               : m_wdata[DATA_WIDTH-1:0];
  assign w_frame_wdata = w_sel_mode ? w_sel_wdata : {DATA_WIDTH{1'b0}};

  // The read timeout fires on the cycle the incremented count reaches TIMEOUT_CYCLES-1.
  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_timeout = (w_cnt_nxt == CW'(TIMEOUT_CYCLES - 1));

  // TX has finished once busy has been seen high and is now low.
  assign w_tx_fall = r_busy_seen & ~u_tx_busy;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (|m_req) w_state_nxt = S_GRANT;
      S_GRANT:   w_state_nxt = S_START;
      S_START:   w_state_nxt = S_TX_WAIT;
      S_TX_WAIT: if (w_tx_fall) w_state_nxt = r_mode ? S_DONE : S_RD_WAIT;
      S_RD_WAIT: if (u_rx_valid || w_timeout) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state, so a reset clears them at once.
  always_comb begin
    m_grant    = 2'b00;
    m_done     = 2'b00;
    m_rdata    = '0;
    m_err      = 1'b0;
    u_tx_start = 1'b0;
    case (r_state)
      S_GRANT: m_grant    = r_win ? 2'b10 : 2'b01;
      S_START: u_tx_start = 1'b1;
      S_DONE: begin
        m_done  = r_win ? 2'b10 : 2'b01;
        m_rdata = r_rdata;
        m_err   = r_err;
      end
      default: ;
    endcase
  end

  assign busy      = (r_state != S_IDLE);
  assign u_tx_data = r_tx_data;
  assign dbg_state = r_state;

  // Transaction datapath: winner, frame latch, TX busy tracking, read counter and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win       <= 1'b0;
      r_last      <= 1'b1;
      r_mode      <= 1'b0;
      r_tx_data   <= '0;
      r_busy_seen <= 1'b0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Fields are captured on the edge into GRANT. This puts the frame on
          // u_tx_data during the grant cycle; the requester still holds the
          // fields then.
          if (|m_req) begin
            r_win     <= w_win;
            r_mode    <= w_sel_mode;
            r_tx_data <= {w_sel_mode, w_sel_addr, w_frame_wdata};
            r_rdata   <= '0;
            r_err     <= 1'b0;
          end
        end
        S_GRANT: begin
          r_last      <= r_win;
          r_busy_seen <= 1'b0;
        end
        S_START: begin
          if (u_tx_busy) r_busy_seen <= 1'b1;
        end
        S_TX_WAIT: begin
          if (u_tx_busy) r_busy_seen <= 1'b1;
          r_cnt <= '0;
        end
        S_RD_WAIT: begin
          r_cnt <= w_cnt_nxt;
          if (u_rx_valid) begin
            r_rdata <= u_rx_data;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bb_link_scheduler.sv
// Bench for bb_link_scheduler: per-requester job queues, a UART TX/RX
// model, and a transaction-level reference (round-robin order, frame
// contents, completion cycle and result).
module tb_bb_link_scheduler;

  localparam int DW = 8;
  localparam int AW = 13;
  localparam int TO = 100;
  localparam int FW = DW + AW + 1;

  typedef struct {
    logic          mode;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            rxd;    // RX byte arrives rxd cycles after TX busy falls; 0 = never
    logic [DW-1:0] rxb;
    logic          spur;   // stray RX strobe during TX_WAIT
  } job_t;

  // Clock / reset.
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT signals.
  logic [1:0]      m_req     = '0;
  logic [1:0]      m_mode    = '0;
  logic [2*AW-1:0] m_addr    = '0;
  logic [2*DW-1:0] m_wdata   = '0;
  logic [1:0]      m_grant;
  logic [1:0]      m_done;
  logic [DW-1:0]   m_rdata;
  logic            m_err;
  logic            busy;
  logic [FW-1:0]   u_tx_data;
  logic            u_tx_start;
  logic            u_tx_busy  = 1'b0;
  logic [DW-1:0]   u_rx_data  = '0;
  logic            u_rx_valid = 1'b0;
  logic [2:0]      dbg_state;

  bb_link_scheduler #(
    .DATA_WIDTH(DW), .BB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_mode(m_mode), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_grant(m_grant), .m_done(m_done), .m_rdata(m_rdata), .m_err(m_err),
    .busy(busy), .u_tx_data(u_tx_data), .u_tx_start(u_tx_start),
    .u_tx_busy(u_tx_busy), .u_rx_data(u_rx_data), .u_rx_valid(u_rx_valid),
    .dbg_state(dbg_state)
  );

  // Scoreboard state.
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [FW-1:0] exp_q[$];
  job_t          q0[$];
  job_t          q1[$];
  job_t          act0, act1, cur_job;
  int            grant_log[$];

  int            cyc          = 0;
  logic [1:0]    pend_prev    = '0;
  logic          model_last   = 1'b1;
  int            cur_w        = 0;
  logic          in_txn       = 1'b0;
  logic          in_rd        = 1'b0;
  int            grant_cyc    = 0;
  logic          awaiting     = 1'b0;
  int            exp_done_cyc = 0;
  int            exp_w_done   = 0;
  logic [DW-1:0] exp_rdata    = '0;
  logic          exp_err      = 1'b0;
  logic          post_done    = 1'b0;
  int            uart_phase   = 0;
  int            uart_wait    = 0;
  int            uart_len     = 0;
  int            rx_cyc       = -1;
  logic [DW-1:0] rx_byte      = '0;
  int            spur_cyc     = -1;
  int            done_count   = 0;
  logic [FW-1:0] last_frame   = '0;
  logic [DW-1:0] last_rdata   = '0;
  logic          last_err     = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_job(input int who, input logic mode, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int rxd,
                          input logic [DW-1:0] rxb, input logic spur);
    job_t j;
    j.mode = mode; j.addr = addr; j.wdata = wdata;
    j.rxd = rxd; j.rxb = rxb; j.spur = spur;
    if (who == 0) q0.push_back(j);
    else          q1.push_back(j);
  endtask

  task automatic wait_all(input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m_req != 2'b00 || in_txn || awaiting)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", (n < budget) ? 32'd1 : 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // Per-cycle monitor, reference model and drivers (all at the falling edge).
  always @(negedge clk) begin
    int            ew;
    logic [FW-1:0] f;
    cyc++;
    if (rst) begin
      in_txn = 1'b0; in_rd = 1'b0; awaiting = 1'b0; post_done = 1'b0;
      uart_phase = 0; u_tx_busy = 1'b0; u_rx_valid = 1'b0; rx_cyc = -1;
      m_req = 2'b00; model_last = 1'b1; pend_prev = 2'b00;
      exp_q.delete();
    end else begin
      // Grant: round-robin over the requests that were present during arbitration.
      if (m_grant != 2'b00) begin
        ew = (pend_prev == 2'b11) ? (model_last ? 0 : 1) : (pend_prev[1] ? 1 : 0);
        check_eq("grant_onehot", m_grant, 32'(1) << ew);
        check_eq("grant_while_busy", in_txn, 0);
        grant_log.push_back(m_grant[1] ? 1 : 0);
        model_last = ew[0];
        cur_w      = ew;
        cur_job    = (ew == 0) ? act0 : act1;
        in_txn     = 1'b1;
        grant_cyc  = cyc;
        f = {cur_job.mode, cur_job.addr, cur_job.mode ? cur_job.wdata : 8'h00};
        exp_q.push_back(f);
        check_eq("frame_at_grant", u_tx_data, f);
        m_req[ew] = 1'b0;
      end
      if (u_tx_start) begin
        check_eq("start_latency", cyc - grant_cyc, 1);
        last_frame = u_tx_data;
        if (exp_q.size() == 0) check_eq("start_unexpected", 1, 0);
        else begin
          f = exp_q.pop_front();
          check_eq("frame_at_start", u_tx_data, f);
        end
        uart_phase = 1;
        uart_wait  = $urandom_range(0, 2);
        uart_len   = $urandom_range(3, 10);
      end
      if (m_done != 2'b00) begin
        check_eq("done_expected", awaiting, 1);
        if (awaiting) begin
          check_eq("done_cycle", cyc, exp_done_cyc);
          check_eq("done_owner", m_done, 32'(1) << exp_w_done);
          check_eq("done_rdata", m_rdata, exp_rdata);
          check_eq("done_err", m_err, exp_err);
          check_eq("busy_in_done", busy, 1);
        end
        done_count++;
        last_rdata = m_rdata;
        last_err   = m_err;
        awaiting = 1'b0; in_txn = 1'b0; in_rd = 1'b0; post_done = 1'b1;
      end else if (post_done) begin
        check_eq("idle_after_done", busy, 0);
        check_eq("no_grant_after_done", m_grant, 0);
        post_done = 1'b0;
      end
      if (awaiting && cyc > exp_done_cyc) begin
        check_eq("done_missing", 0, 1);
        awaiting = 1'b0; in_txn = 1'b0; in_rd = 1'b0;
      end

      // RX strobes: scheduled read data and stray strobes.
      u_rx_valid = 1'b0;
      if (cyc == rx_cyc)   begin u_rx_valid = 1'b1; u_rx_data = rx_byte; end
      if (cyc == spur_cyc) begin u_rx_valid = 1'b1; u_rx_data = 8'h5A;   end

      // UART TX model: optional delay, busy high for a while, then the fall.
      if (uart_phase == 1) begin
        if (uart_wait == 0) begin u_tx_busy = 1'b1; uart_phase = 2; end
        else uart_wait--;
      end else if (uart_phase == 2) begin
        if (uart_len == 0) begin
          u_tx_busy  = 1'b0;
          uart_phase = 0;
          if (in_txn) begin
            awaiting   = 1'b1;
            exp_w_done = cur_w;
            if (cur_job.mode) begin
              exp_done_cyc = cyc + 1; exp_rdata = '0; exp_err = 1'b0;
            end else begin
              in_rd = 1'b1;
              if (cur_job.rxd == 0) begin
                exp_done_cyc = cyc + TO; exp_rdata = '0; exp_err = 1'b1; rx_cyc = -1;
              end else begin
                rx_cyc       = cyc + cur_job.rxd;
                rx_byte      = cur_job.rxb;
                exp_done_cyc = cyc + cur_job.rxd + 1;
                exp_rdata    = cur_job.rxb;
                exp_err      = 1'b0;
              end
            end
            if (cur_job.spur) begin u_rx_valid = 1'b1; u_rx_data = 8'hC3; end
          end
        end else uart_len--;
      end

      // Issue queued jobs; a requester holds its request until granted.
      if (!m_req[0] && q0.size() != 0) begin
        act0 = q0.pop_front();
        m_req[0] = 1'b1; m_mode[0] = act0.mode;
        m_addr[AW-1:0] = act0.addr; m_wdata[DW-1:0] = act0.wdata;
      end
      if (!m_req[1] && q1.size() != 0) begin
        act1 = q1.pop_front();
        m_req[1] = 1'b1; m_mode[1] = act1.mode;
        m_addr[2*AW-1:AW] = act1.addr; m_wdata[2*DW-1:DW] = act1.wdata;
      end
      pend_prev = m_req;
    end
  end

  // Safety net against a hang.
  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  // Test sequence.
  initial begin
    int base, dc, r, who;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant", m_grant, 0);
    check_eq("rst_done", m_done, 0);
    check_eq("rst_start", u_tx_start, 0);
    check_eq("rst_txdata", u_tx_data, 0);
    #2 rst = 1'b0;

    // Single write from requester 0.
    push_job(0, 1'b1, 13'h0A5, 8'h3C, 0, 8'h00, 1'b0);
    wait_all(200);
    check_eq("t1_frame", last_frame, 22'h20A53C);
    check_eq("t1_err", last_err, 0);

    // Read from requester 1; write data must not appear in the frame.
    push_job(1, 1'b0, 13'h1FFF, 8'hAA, 60, 8'hE7, 1'b0);
    wait_all(300);
    check_eq("t2_frame", last_frame, 22'h1FFF00);
    check_eq("t2_rdata", last_rdata, 8'hE7);
    check_eq("t2_err", last_err, 0);

    // Both requesters busy continuously: alternating grants.
    base = grant_log.size();
    push_job(0, 1'b1, 13'h0011, 8'h11, 0, 8'h00, 1'b0);
    push_job(1, 1'b1, 13'h0022, 8'h22, 0, 8'h00, 1'b0);
    push_job(0, 1'b1, 13'h0033, 8'h33, 0, 8'h00, 1'b0);
    push_job(1, 1'b1, 13'h0044, 8'h44, 0, 8'h00, 1'b0);
    wait_all(600);
    check_eq("t3_count", grant_log.size() - base, 4);
    if (grant_log.size() - base == 4) begin
      check_eq("t3_g0", grant_log[base],   0);
      check_eq("t3_g1", grant_log[base+1], 1);
      check_eq("t3_g2", grant_log[base+2], 0);
      check_eq("t3_g3", grant_log[base+3], 1);
    end

    // Read timeout, then a following request is still served.
    push_job(0, 1'b0, 13'h0ABC, 8'h00, 0, 8'h00, 1'b0);
    wait_all(400);
    check_eq("t4_err", last_err, 1);
    check_eq("t4_rdata", last_rdata, 0);
    push_job(1, 1'b1, 13'h0123, 8'h99, 0, 8'h00, 1'b0);
    wait_all(200);
    check_eq("t4_next_err", last_err, 0);

    // RX byte on the very last waiting cycle: data beats the timeout.
    push_job(0, 1'b0, 13'h0777, 8'h00, TO - 1, 8'h9C, 1'b0);
    wait_all(400);
    check_eq("edge_rdata", last_rdata, 8'h9C);
    check_eq("edge_err", last_err, 0);

    // Stray RX strobes in IDLE and TX_WAIT are ignored.
    dc = done_count;
    spur_cyc = cyc + 2;
    repeat (6) @(negedge clk);
    check_eq("t5_no_done", done_count, dc);
    push_job(1, 1'b0, 13'h0456, 8'h00, 20, 8'h42, 1'b1);
    wait_all(300);
    check_eq("t5_rdata", last_rdata, 8'h42);
    check_eq("t5_one_done", done_count, dc + 1);

    // Randomized mix against the reference model.
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 6; k++) begin
        who = $urandom_range(0, 1);
        r   = $urandom_range(0, 7);
        push_job(who, 1'($urandom_range(0, 1)), 13'($urandom), 8'($urandom),
                 (r == 0) ? 0 : (r == 1) ? TO - 1 : $urandom_range(1, TO - 2),
                 8'($urandom), 1'($urandom_range(0, 1)));
      end
      wait_all(2000);
    end

    // Reset while waiting for read data aborts silently and restores arbitration.
    push_job(0, 1'b0, 13'h0321, 8'h00, 0, 8'h00, 1'b0);
    r = 0;
    while (!in_rd && r < 200) begin @(negedge clk); r++; end
    check_eq("t6_reached_rd", in_rd, 1);
    repeat (10) @(negedge clk);
    dc = done_count;
    #2 rst = 1'b1;
    #1;
    check_eq("t6_busy", busy, 0);
    check_eq("t6_done", m_done, 0);
    check_eq("t6_grant", m_grant, 0);
    check_eq("t6_start", u_tx_start, 0);
    check_eq("t6_txdata", u_tx_data, 0);
    check_eq("t6_err", m_err, 0);
    check_eq("t6_rdata", m_rdata, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    base = grant_log.size();
    push_job(0, 1'b1, 13'h0001, 8'h01, 0, 8'h00, 1'b0);
    push_job(1, 1'b1, 13'h0002, 8'h02, 0, 8'h00, 1'b0);
    wait_all(400);
    check_eq("t6_first_grant", (grant_log.size() > base) ? grant_log[base] : 2, 0);
    check_eq("t6_done_count", done_count, dc + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
